// File: rtl/sc_gamecontroller.sv
`default_nettype none
//==============================================================================
// Module      : sc_gamecontroller
// Description : Top-level game-flow FSM for Frogger. Tracks the game phase
//               (await start / playing / game over), issues the active-low
//               one-cycle level-up pulse to the level counter, asks the frog
//               logic to reposition the frog, and latches the win/lose result
//               for the display while the game is over.
//
// Ports:
//   SC_GAMECONTROLLER_CLOCK_50            in   system clock, 50 MHz
//   SC_GAMECONTROLLER_RESET_InLow         in   asynchronous active-low reset
//   SC_GAMECONTROLLER_Start_InLow         in   debounced start button, active low
//   SC_GAMECONTROLLER_FrogRow_InBus       in   current frog row
//   SC_GAMECONTROLLER_Collision_InHigh    in   frog hit a car / fell in water
//   SC_GAMECONTROLLER_Level_InBus         in   registered level counter feedback
//   SC_GAMECONTROLLER_CurrentState_OutBus out  0=AWAITSTART 1=STARTGAME 2=ENDGAME
//   SC_GAMECONTROLLER_CountSignal_OutLow  out  one-cycle active-low level-up pulse
//   SC_GAMECONTROLLER_FrogReset_OutHigh   out  one-cycle pulse: frog to start row
//   SC_GAMECONTROLLER_Win_OutHigh         out  held in ENDGAME after a win
//   SC_GAMECONTROLLER_Lose_OutHigh        out  held in ENDGAME after a collision
//
// Revision    : 1.0 - initial release
//==============================================================================
module sc_gamecontroller #(
    parameter int CURRENTSTATE_DATAWIDTH = 2,
    parameter int LEVELCOUNTER_DATAWIDTH = 3,
    parameter int ROW_DATAWIDTH          = 4,
    parameter int GOAL_ROW               = 0,
    parameter int LAST_LEVEL             = 3,
    parameter int ENDHOLD_CYCLES         = 25000000,
    parameter int ENDHOLD_DATAWIDTH      = 25
) (
    input  logic                              SC_GAMECONTROLLER_CLOCK_50,
    input  logic                              SC_GAMECONTROLLER_RESET_InLow,
    input  logic                              SC_GAMECONTROLLER_Start_InLow,
    input  logic [ROW_DATAWIDTH-1:0]          SC_GAMECONTROLLER_FrogRow_InBus,
    input  logic                              SC_GAMECONTROLLER_Collision_InHigh,
    input  logic [LEVELCOUNTER_DATAWIDTH-1:0] SC_GAMECONTROLLER_Level_InBus,
    output logic [CURRENTSTATE_DATAWIDTH-1:0] SC_GAMECONTROLLER_CurrentState_OutBus,
    output logic                              SC_GAMECONTROLLER_CountSignal_OutLow,
    output logic                              SC_GAMECONTROLLER_FrogReset_OutHigh,
    output logic                              SC_GAMECONTROLLER_Win_OutHigh,
    output logic                              SC_GAMECONTROLLER_Lose_OutHigh
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam logic [ROW_DATAWIDTH-1:0]          c_GOAL_ROW   = ROW_DATAWIDTH'(GOAL_ROW);
    localparam logic [LEVELCOUNTER_DATAWIDTH-1:0] c_LAST_LEVEL = LEVELCOUNTER_DATAWIDTH'(LAST_LEVEL);
    localparam logic [ENDHOLD_DATAWIDTH-1:0]      c_HOLD_MAX   = ENDHOLD_DATAWIDTH'(ENDHOLD_CYCLES - 1);

    typedef enum logic [CURRENTSTATE_DATAWIDTH-1:0] {
        AWAITSTART = CURRENTSTATE_DATAWIDTH'(0),
        STARTGAME  = CURRENTSTATE_DATAWIDTH'(1),
        ENDGAME    = CURRENTSTATE_DATAWIDTH'(2)
    } state_t;

    //--------------------------------------------------------------------------
    // Registers and next-state wires
    //--------------------------------------------------------------------------
    state_t                         r_state;
    state_t                         w_stateNext;
    logic                           r_startPrev;
    logic                           r_armed;
    logic                           w_armedNext;
    logic [ENDHOLD_DATAWIDTH-1:0]   r_holdCount;
    logic [ENDHOLD_DATAWIDTH-1:0]   w_holdCountNext;
    logic                           r_countSignal;
    logic                           w_countSignalNext;
    logic                           r_frogReset;
    logic                           w_frogResetNext;
    logic                           r_win;
    logic                           w_winNext;
    logic                           r_lose;
    logic                           w_loseNext;

    logic                           w_startFall;
    logic                           w_atGoal;
    logic                           w_lastLevel;
    logic                           w_holdDone;

    // A held button produces a single falling edge because r_startPrev
    // follows the button every cycle.
    assign w_startFall = r_startPrev & ~SC_GAMECONTROLLER_Start_InLow;
    assign w_atGoal    = (SC_GAMECONTROLLER_FrogRow_InBus == c_GOAL_ROW);
    assign w_lastLevel = (SC_GAMECONTROLLER_Level_InBus == c_LAST_LEVEL);
    assign w_holdDone  = (r_holdCount == c_HOLD_MAX);

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge SC_GAMECONTROLLER_CLOCK_50 or negedge SC_GAMECONTROLLER_RESET_InLow) begin
        if (!SC_GAMECONTROLLER_RESET_InLow) begin
            r_state       <= AWAITSTART;
            r_startPrev   <= 1'b1;
            r_armed       <= 1'b0;
            r_holdCount   <= '0;
            r_countSignal <= 1'b1;
            r_frogReset   <= 1'b0;
            r_win         <= 1'b0;
            r_lose        <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_startPrev   <= SC_GAMECONTROLLER_Start_InLow;
            r_armed       <= w_armedNext;
            r_holdCount   <= w_holdCountNext;
            r_countSignal <= w_countSignalNext;
            r_frogReset   <= w_frogResetNext;
            r_win         <= w_winNext;
            r_lose        <= w_loseNext;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and next-output logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_stateNext       = r_state;
        w_armedNext       = r_armed;
        w_holdCountNext   = '0;
        w_countSignalNext = 1'b1;
        w_frogResetNext   = 1'b0;
        w_winNext         = 1'b0;
        w_loseNext        = 1'b0;

        case (r_state)
            AWAITSTART: begin
                w_armedNext = 1'b0;
                if (w_startFall) begin
                    w_stateNext     = STARTGAME;
                    w_frogResetNext = 1'b1;
                end
            end

            STARTGAME: begin
                // The frog must leave the goal row before a goal hit counts,
                // so sitting on the goal row yields only one level-up.
                if (!w_atGoal) begin
                    w_armedNext = 1'b1;
                end
                if (SC_GAMECONTROLLER_Collision_InHigh) begin
                    w_stateNext = ENDGAME;
                    w_loseNext  = 1'b1;
                end else if (w_atGoal && r_armed) begin
                    if (w_lastLevel) begin
                        w_stateNext = ENDGAME;
                        w_winNext   = 1'b1;
                    end else begin
                        w_countSignalNext = 1'b0;
                        w_frogResetNext   = 1'b1;
                        w_armedNext       = 1'b0;
                    end
                end
            end

            ENDGAME: begin
                w_winNext       = r_win;
                w_loseNext      = r_lose;
                w_armedNext     = 1'b0;
                // Saturating hold counter; start is only honoured once it
                // has reached its terminal value.
                w_holdCountNext = w_holdDone ? r_holdCount : r_holdCount + 1'b1;
                if (w_holdDone && w_startFall) begin
                    w_stateNext     = AWAITSTART;
                    w_winNext       = 1'b0;
                    w_loseNext      = 1'b0;
                    w_holdCountNext = '0;
                end
            end

            default: begin
                // Unused encoding (e.g. after an upset): recover to idle.
                w_stateNext = AWAITSTART;
                w_armedNext = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign SC_GAMECONTROLLER_CurrentState_OutBus = r_state;
    assign SC_GAMECONTROLLER_CountSignal_OutLow  = r_countSignal;
    assign SC_GAMECONTROLLER_FrogReset_OutHigh   = r_frogReset;
    assign SC_GAMECONTROLLER_Win_OutHigh         = r_win;
    assign SC_GAMECONTROLLER_Lose_OutHigh        = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_sc_gamecontroller.sv
`default_nettype none
//==============================================================================
// Module      : tb_sc_gamecontroller
// Description : Scoreboard bench for sc_gamecontroller. Stimulus pushes the
//               expected output tuple and the cycle it must appear on; the
//               monitor pops an entry each time the DUT outputs change.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sc_gamecontroller;

    localparam int c_HOLD = 16;

    logic       clk       = 1'b0;
    logic       rstN      = 1'b1;
    logic       startN    = 1'b1;
    logic [3:0] frogRow   = 4'd0;
    logic       collision = 1'b0;
    logic [2:0] level     = 3'd1;

    logic [1:0] state;
    logic       countN;
    logic       frogReset;
    logic       win;
    logic       lose;

    sc_gamecontroller #(
        .ENDHOLD_CYCLES    (c_HOLD),
        .ENDHOLD_DATAWIDTH (5)
    ) dut (
        .SC_GAMECONTROLLER_CLOCK_50            (clk),
        .SC_GAMECONTROLLER_RESET_InLow         (rstN),
        .SC_GAMECONTROLLER_Start_InLow         (startN),
        .SC_GAMECONTROLLER_FrogRow_InBus       (frogRow),
        .SC_GAMECONTROLLER_Collision_InHigh    (collision),
        .SC_GAMECONTROLLER_Level_InBus         (level),
        .SC_GAMECONTROLLER_CurrentState_OutBus (state),
        .SC_GAMECONTROLLER_CountSignal_OutLow  (countN),
        .SC_GAMECONTROLLER_FrogReset_OutHigh   (frogReset),
        .SC_GAMECONTROLLER_Win_OutHigh         (win),
        .SC_GAMECONTROLLER_Lose_OutHigh        (lose)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // vec = {state[1:0], countN, frogReset, win, lose}; cyc < 0 means any cycle
    typedef struct {
        int         cyc;
        logic [5:0] vec;
        string      name;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;

    task automatic expectAt(input int c, input logic [1:0] st, input logic cnt,
                            input logic fr, input logic w, input logic l,
                            input string nm);
        exp_t e;
        e.cyc  = c;
        e.vec  = {st, cnt, fr, w, l};
        e.name = nm;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples away from the active edge, and also right after an
    // asynchronous reset assertion.
    initial begin : p_monitor
        logic [5:0] prevVec;
        logic [5:0] cur;
        bit         first;
        exp_t       e;
        first   = 1'b1;
        prevVec = '0;
        forever begin
            @(negedge clk or negedge rstN);
            #1;
            cur = {state, countN, frogReset, win, lose};
            if (first || cur != prevVec) begin
                first   = 1'b0;
                prevVec = cur;
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL unexpected_change: got vec=%b at cycle %0d, expected no change", cur, cyc);
                end else begin
                    e = expQ.pop_front();
                    if (cur == e.vec && (e.cyc < 0 || e.cyc == cyc))
                        passes++;
                    else
                        $display("FAIL %s: got vec=%b at cycle %0d, expected vec=%b at cycle %0d",
                                 e.name, cur, cyc, e.vec, e.cyc);
                end
            end
        end
    end

    task automatic startPress(input string nm);
        int k;
        startN = 1'b0;
        k = cyc;
        expectAt(k + 1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, {nm, "_go"});
        expectAt(k + 2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, {nm, "_frogreset_end"});
    endtask

    task automatic levelUp(input string nm);
        int k;
        frogRow = 4'd5;
        tick();
        tick();
        frogRow = 4'd0;
        k = cyc;
        expectAt(k + 1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, {nm, "_pulse"});
        expectAt(k + 2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, {nm, "_pulse_end"});
        repeat (20) tick();
    endtask

    initial begin : p_stim
        int k;

        // Reset
        #1 rstN = 1'b0;
        expectAt(-1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
        repeat (3) tick();
        rstN = 1'b1;
        tick();

        // Start held for 10 cycles: one edge, one frog-reset pulse
        startPress("start1");
        repeat (10) tick();
        startN = 1'b1;
        tick();

        // Two level-ups at level 1
        levelUp("lvl1");
        levelUp("lvl2");

        // Win at the last level, then end-hold behaviour
        level   = 3'd3;
        frogRow = 4'd5;
        tick();
        tick();
        frogRow = 4'd0;
        k = cyc;
        expectAt(k + 1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, "win");
        repeat (5) tick();
        startN = 1'b0;            // early press: hold counter still running
        tick();
        tick();
        startN = 1'b1;
        repeat (13) tick();
        startN = 1'b0;            // hold counter saturated by now
        expectAt(k + 21, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_exit");
        tick();
        startN = 1'b1;
        level  = 3'd1;
        tick();

        // Collision wins over a simultaneous goal hit
        startPress("start2");
        tick();
        tick();
        startN  = 1'b1;
        frogRow = 4'd5;
        tick();
        tick();
        frogRow   = 4'd0;
        collision = 1'b1;
        k = cyc;
        expectAt(k + 1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, "lose");
        tick();
        collision = 1'b0;
        repeat (20) tick();
        startN = 1'b0;
        k = cyc;
        expectAt(k + 1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, "lose_exit");
        tick();
        startN = 1'b1;
        tick();

        // Asynchronous reset while the level-up pulse is low
        startPress("start3");
        tick();
        tick();
        startN  = 1'b1;
        frogRow = 4'd5;
        tick();
        tick();
        frogRow = 4'd0;
        k = cyc;
        expectAt(k + 1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, "pulse_before_reset");
        expectAt(k + 1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, "async_reset_immediate");
        tick();
        #6 rstN = 1'b0;
        repeat (2) tick();
        rstN = 1'b1;
        repeat (3) tick();

        // Every expected event must have been observed
        checks++;
        if (expQ.size() == 0)
            passes++;
        else
            $display("FAIL leftover_expectations: got %0d pending (first %s), expected 0",
                     expQ.size(), expQ[0].name);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sc_gamecontroller.md
Name: sc_gamecontroller

Overview:
- Top-level game-flow FSM for Frogger.
- Drives the 2-bit current-state bus and the active-low one-cycle level-up pulse consumed by the level counter.
- Also generates frog-reposition and win/lose flags.
- Sits between the debounced start button / frog-position / collision logic (upstream) and the level counter plus display logic (downstream).

Parameters:
- CURRENTSTATE_DATAWIDTH, 2, width of the state bus.
- LEVELCOUNTER_DATAWIDTH, 3, width of the level feedback input.
- ROW_DATAWIDTH, 4, width of the frog row input.
- GOAL_ROW, 0, row index that counts as reaching the far bank.
- LAST_LEVEL, 3, level value at which a goal hit ends the game as a win.
- ENDHOLD_CYCLES, 25000000, cycles ENDGAME ignores start (0.5 s at 50 MHz).
- ENDHOLD_DATAWIDTH, 25, width of the hold counter.

Ports:
- SC_GAMECONTROLLER_CLOCK_50  in  1  system clock, 50 MHz
- SC_GAMECONTROLLER_RESET_InLow  in  1  asynchronous active-low reset
- SC_GAMECONTROLLER_Start_InLow  in  1  debounced start button, active low
- SC_GAMECONTROLLER_FrogRow_InBus  in  ROW_DATAWIDTH  current frog row
- SC_GAMECONTROLLER_Collision_InHigh  in  1  frog hit a car or fell in water (level signal)
- SC_GAMECONTROLLER_Level_InBus  in  LEVELCOUNTER_DATAWIDTH  registered level counter output (feedback)
- SC_GAMECONTROLLER_CurrentState_OutBus  out  CURRENTSTATE_DATAWIDTH  0=AWAITSTART, 1=STARTGAME, 2=ENDGAME
- SC_GAMECONTROLLER_CountSignal_OutLow  out  1  one-cycle active-low level-up pulse
- SC_GAMECONTROLLER_FrogReset_OutHigh  out  1  one-cycle pulse: return frog to start row
- SC_GAMECONTROLLER_Win_OutHigh  out  1  held high in ENDGAME after a win
- SC_GAMECONTROLLER_Lose_OutHigh  out  1  held high in ENDGAME after a collision

Behaviour:
- Interface: one clock, SC_GAMECONTROLLER_CLOCK_50. Reset SC_GAMECONTROLLER_RESET_InLow is asynchronous, active low.
- Reset values:
  - state = AWAITSTART (0)
  - CountSignal = 1, FrogReset = 0, Win = 0, Lose = 0
  - hold counter = 0, armed = 0
  - start_prev = 1
- Reset asserted mid-game returns to these values immediately, with no pulse emitted.
- All outputs are registered. Each output changes on the clock edge after the triggering input condition is sampled (1-cycle latency).
- Start edge: start_fall = (start_prev==1 && Start_InLow==0). start_prev is registered every cycle. A held button yields exactly one edge.
- State encoding 3 is never produced. If it is reached (SEU), the next state is AWAITSTART.
- AWAITSTART:
  - Win = Lose = 0.
  - On start_fall: go to STARTGAME, FrogReset = 1 for one cycle, armed = 0.
- STARTGAME:
  - armed is set on any cycle where FrogRow != GOAL_ROW.
  - Collision = 1 (highest priority): go to ENDGAME, Lose = 1, no count pulse, FrogReset = 0.
  - Else if FrogRow == GOAL_ROW, armed = 1, and Level_InBus == LAST_LEVEL: go to ENDGAME, Win = 1, no count pulse.
  - Else if FrogRow == GOAL_ROW, armed = 1, and Level_InBus != LAST_LEVEL:
    - CountSignal = 0 for exactly one cycle, FrogReset = 1 for one cycle, armed = 0.
    - Stay in STARTGAME.
    - A second pulse requires the frog to leave GOAL_ROW first.
  - start_fall is ignored in STARTGAME.
- ENDGAME:
  - Win and Lose are held.
  - Hold counter increments from 0 and saturates at ENDHOLD_CYCLES-1.
  - start_fall is ignored while the counter < ENDHOLD_CYCLES-1.
  - Afterwards start_fall: go to AWAITSTART, clear Win/Lose, clear the counter.
- CountSignal is never low for more than one consecutive cycle (downstream counter increments every low cycle).
- CountSignal is never low outside STARTGAME.
- Win and Lose are mutually exclusive.

Test Plan:
- Reset: hold RESET_InLow=0 for 3 cycles then release. Expect State=0, CountSignal=1, FrogReset=0, Win=0, Lose=0. Then Start low for 10 cycles. Expect State=1 one cycle after the first low sample, FrogReset high for exactly 1 cycle.
- Level-up: in STARTGAME set FrogRow=5 for 2 cycles, then FrogRow=0 for 20 cycles with Level=1. Expect exactly one CountSignal low cycle and one FrogReset pulse, State stays 1. Set FrogRow=5 then 0 again. Expect a second single pulse.
- Win: Level=3 (LAST_LEVEL), FrogRow 5 then 0. Expect State=2, Win=1, Lose=0, CountSignal stays 1.
- Collision priority: FrogRow 5 then 0 with Collision=1 in the same cycle, Level=1. Expect State=2, Lose=1, no CountSignal pulse.
- End hold (ENDHOLD_CYCLES=16 in bench): in ENDGAME press Start at hold cycle 5. Expect State stays 2. Release, press again at cycle 20. Expect State=0, Win=Lose=0.
- Async reset mid-pulse: assert RESET_InLow=0 between clock edges in the cycle CountSignal is low. Expect CountSignal=1 and State=0 immediately, before the next clock edge.
